// File: rtl/shift_add_multiplier_pkg.sv
// shift_add_multiplier_pkg: shared state encoding and counter sizing for the multiplier
package shift_add_multiplier_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Wide enough to hold the value N itself, not just N-1
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/register.sv
// register: passive N-bit store driven by clear/load/shift-right strobes
//   clk, rst_n : clock and asynchronous active-low reset
//   cl, ld, sr : clear, parallel load from d, shift right inserting ir at the MSB
//   ir, d, q   : shift-in bit, load data, stored value
module register #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cl,
    input  logic                  ld,
    input  logic                  sr,
    input  logic                  ir,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (cl) q <= '0;
        else if (ld) q <= d;
        else if (sr) q <= {ir, q[DATA_WIDTH-1:1]};
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier behind start/busy/done
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : request, accepted only in IDLE
//   a, b       : multiplicand and multiplier, captured on the accepting edge
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse when product is valid
//   product    : {A,Q}, held until the next accepted start
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product
);
    localparam int N  = DATA_WIDTH;
    localparam int CW = cnt_w(N);

    state_t          r_state, w_next;
    logic [N-1:0]    r_a, r_b;
    logic [N-1:0]    w_m, w_acc, w_q;
    logic            r_c;
    logic [CW-1:0]   r_cnt;
    logic [N:0]      w_sum;
    logic            w_load, w_add, w_shift;

    assign w_load  = r_state == S_LOAD;
    assign w_add   = r_state == S_ADD && w_q[0];
    assign w_shift = r_state == S_SHIFT;
    assign w_sum   = {1'b0, w_acc} + {1'b0, w_m};

    register #(.DATA_WIDTH(N)) u_m (
        .clk(clk), .rst_n(rst_n), .cl(1'b0), .ld(w_load), .sr(1'b0),
        .ir(1'b0), .d(r_a), .q(w_m)
    );

    register #(.DATA_WIDTH(N)) u_a (
        .clk(clk), .rst_n(rst_n), .cl(w_load), .ld(w_add), .sr(w_shift),
        .ir(r_c), .d(w_sum[N-1:0]), .q(w_acc)
    );

    // Q's shift-in is A[0] before the shift, so {C,A,Q} moves right as one word
    register #(.DATA_WIDTH(N)) u_q (
        .clk(clk), .rst_n(rst_n), .cl(1'b0), .ld(w_load), .sr(w_shift),
        .ir(w_acc[0]), .d(r_b), .q(w_q)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_a <= a;
                r_b <= b;
            end
            if (w_load || w_shift) r_c <= 1'b0;
            else if (w_add) r_c <= w_sum[N];
            if (w_load) r_cnt <= CW'(N);
            else if (w_shift) r_cnt <= r_cnt - 1'b1;
        end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_ADD;
            S_ADD:   w_next = S_SHIFT;
            S_SHIFT: w_next = r_cnt == CW'(1) ? S_DONE : S_ADD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign busy    = r_state != S_IDLE;
    assign done    = r_state == S_DONE;
    assign product = {w_acc, w_q};
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: randomized self-checking bench against an arithmetic product model
module tb_shift_add_multiplier;
    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int vec = 0;
    int miss = 0;

    shift_add_multiplier #(.DATA_WIDTH(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*N-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
        longint unsigned p;
        p = longint'(x) * longint'(y);
        return p[2*N-1:0];
    endfunction

    // One operation; operands are scrambled after acceptance, and optionally a
    // second start with different operands is pulsed at cycle 10 while busy.
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input bit spur);
        logic [2*N-1:0] e;
        int j;
        e = model(x, y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        chk("busy_on", busy, 1);
        j = 1;
        while (!done && j < 100) begin
            @(negedge clk);
            j++;
            if (spur && j == 10) begin
                start = 1'b1;
                a = N'($urandom);
                b = N'($urandom);
            end
            if (spur && j == 11) start = 1'b0;
        end
        chk("latency", j, 2 * N + 2);
        chk("busy_in_done", busy, 1);
        chk("product", product, e);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_off", busy, 0);
        chk("hold", product, e);
    endtask

    initial begin
        int t, last, cnt;
        logic [2*N-1:0] e;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h0003, 16'h0005, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0);
        run_op(16'h1234, 16'h0000, 1'b0);
        run_op(16'h8000, 16'h0002, 1'b0);
        run_op(16'h0000, 16'hBEEF, 1'b0);
        run_op(16'h0007, 16'h0009, 1'b1);
        chk("spur_ignored", product, 32'h0000003F);
        for (int i = 0; i < 20; i++) run_op(N'($urandom), N'($urandom), i[0]);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        a = 16'h4321;
        b = 16'h1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_product", product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h000A, 16'h000B, 1'b0);

        // start held high: IDLE re-accepts on the edge after DONE
        e = model(16'h0100, 16'h0100);
        @(negedge clk);
        a = 16'h0100;
        b = 16'h0100;
        start = 1'b1;
        t = 0;
        last = -1;
        cnt = 0;
        while (cnt < 3 && t < 200) begin
            @(negedge clk);
            t++;
            if (done) begin
                chk("held_product", product, e);
                if (last >= 0) chk("held_period", t - last, 2 * N + 3);
                last = t;
                cnt++;
            end
        end
        chk("held_pulses", cnt, 3);
        start = 1'b0;
        repeat (2 * N + 4) @(negedge clk);
        chk("held_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
